// File: rtl/sha3_axis_absorber.sv
// AXI-Stream byte absorber for the SHA3 core: splits a message into rate-sized
// blocks, applies FIPS-202 padding and hands each block off as a 5x5x64 state.
module sha3_axis_absorber #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic                         TVALID,
    output logic                         TREADY,
    input  logic [DATA_WIDTH-1:0]        TDATA,
    input  logic [KEEP_WIDTH-1:0]        TKEEP,
    input  logic                         TLAST,
    input  logic [1:0]                   TUSER,
    output logic [0:4][0:4][63:0]        D_out,
    output logic                         D_valid,
    input  logic                         D_ready,
    output logic                         D_first,
    output logic                         D_last,
    output logic [1:0]                   D_mode
);

    localparam int BLK_BITS = 1152;
    localparam int IDX_W    = 11;
    localparam int CNT_W    = 8;
    localparam int POP_W    = $clog2(KEEP_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_HOLD,
        ST_PADBLK
    } state_t;

    function automatic logic [CNT_W-1:0] rateBytes(input logic [1:0] mode);
        case (mode)
            2'd0:    rateBytes = 8'd144;
            2'd1:    rateBytes = 8'd136;
            2'd2:    rateBytes = 8'd104;
            default: rateBytes = 8'd72;
        endcase
    endfunction

    state_t                r_state, w_state_n;
    logic [BLK_BITS-1:0]   r_block, w_block_n;
    logic [CNT_W-1:0]      r_cnt, w_cnt_n;
    logic                  r_pend, w_pend_n;
    logic                  r_first, w_first_n;
    logic                  r_last, w_last_n;
    logic [1:0]            r_mode, w_mode_n;

    logic [1:0]            w_mode_eff;
    logic [CNT_W-1:0]      w_rb;
    logic [CNT_W-1:0]      w_rw;
    logic [KEEP_WIDTH-1:0] w_keep;
    logic [DATA_WIDTH-1:0] w_data;
    logic [POP_W-1:0]      w_pop;
    logic [CNT_W-1:0]      w_pos;
    logic [IDX_W-1:0]      w_wbit;
    logic [IDX_W-1:0]      w_pbit;
    logic [IDX_W-1:0]      w_lbit;
    logic [IDX_W-1:0]      w_padbit;
    logic [1599:0]         w_full;

    // TUSER only counts on the very first beat of a message; later beats reuse the latched mode
    assign w_mode_eff = (r_first && (r_cnt == '0)) ? TUSER : r_mode;
    assign w_rb       = rateBytes(w_mode_eff);
    assign w_rw       = w_rb / CNT_W'(KEEP_WIDTH);
    assign w_keep     = TLAST ? TKEEP : {KEEP_WIDTH{1'b1}};
    assign w_pos      = r_cnt * CNT_W'(KEEP_WIDTH) + CNT_W'(w_pop);
    assign w_wbit     = IDX_W'(r_cnt) * IDX_W'(DATA_WIDTH);
    assign w_pbit     = {w_pos, 3'b000};
    assign w_lbit     = {w_rb - 8'd1, 3'b000};
    assign w_padbit   = {rateBytes(r_mode) - 8'd1, 3'b000};

    always_comb begin
        w_data = '0;
        w_pop  = '0;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            w_data[8*k +: 8] = w_keep[k] ? TDATA[8*k +: 8] : 8'h00;
            w_pop            = w_pop + POP_W'(w_keep[k]);
        end
    end

    assign TREADY  = (r_state == ST_FILL) && !ARESET;
    assign D_valid = (r_state == ST_HOLD) && !ARESET;
    assign D_first = (r_state == ST_HOLD) && r_first;
    assign D_last  = (r_state == ST_HOLD) && r_last;
    assign D_mode  = r_mode;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= ST_FILL;
            r_block <= '0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_first <= 1'b1;
            r_last  <= 1'b0;
            r_mode  <= 2'd0;
        end else begin
            r_state <= w_state_n;
            r_block <= w_block_n;
            r_cnt   <= w_cnt_n;
            r_pend  <= w_pend_n;
            r_first <= w_first_n;
            r_last  <= w_last_n;
            r_mode  <= w_mode_n;
        end
    end

    // A block-exact message ends with pending_pad set so a padding-only block follows
    always_comb begin
        w_state_n = r_state;
        w_block_n = r_block;
        w_cnt_n   = r_cnt;
        w_pend_n  = r_pend;
        w_first_n = r_first;
        w_last_n  = r_last;
        w_mode_n  = r_mode;
        case (r_state)
            ST_FILL: begin
                if (TVALID && TREADY) begin
                    w_mode_n                      = w_mode_eff;
                    w_block_n[w_wbit +: DATA_WIDTH] = w_data;
                    w_cnt_n                       = r_cnt + 8'd1;
                    if (TLAST) begin
                        w_state_n = ST_HOLD;
                        if (w_pos < w_rb) begin
                            w_block_n[w_pbit +: 8] = w_block_n[w_pbit +: 8] | 8'h06;
                            w_block_n[w_lbit +: 8] = w_block_n[w_lbit +: 8] | 8'h80;
                            w_last_n               = 1'b1;
                            w_pend_n               = 1'b0;
                        end else begin
                            w_last_n = 1'b0;
                            w_pend_n = 1'b1;
                        end
                    end else if (r_cnt == w_rw - 8'd1) begin
                        w_state_n = ST_HOLD;
                        w_last_n  = 1'b0;
                        w_pend_n  = 1'b0;
                    end
                end
            end
            ST_HOLD: begin
                if (D_ready) begin
                    w_block_n = '0;
                    w_cnt_n   = '0;
                    w_first_n = r_last;
                    w_state_n = r_pend ? ST_PADBLK : ST_FILL;
                end
            end
            ST_PADBLK: begin
                w_block_n                = '0;
                w_block_n[7:0]           = 8'h06;
                w_block_n[w_padbit +: 8] = w_block_n[w_padbit +: 8] | 8'h80;
                w_pend_n                 = 1'b0;
                w_last_n                 = 1'b1;
                w_state_n                = ST_HOLD;
            end
            default: w_state_n = ST_FILL;
        endcase
    end

    // Lane [x][y] carries block bits 64*(x+5y) upward; capacity lanes stay zero
    assign w_full = {448'b0, r_block};

    always_comb begin
        D_out = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                D_out[x][y] = w_full[64*(x+5*y) +: 64];
            end
        end
    end

endmodule

// File: tb/tb_sha3_axis_absorber.sv
// Directed bench for sha3_axis_absorber at DATA_WIDTH=64 with hand-built expected blocks.
module tb_sha3_axis_absorber;

    logic                  ACLK = 1'b0;
    logic                  ARESET;
    logic                  TVALID;
    logic                  TREADY;
    logic [63:0]           TDATA;
    logic [7:0]            TKEEP;
    logic                  TLAST;
    logic [1:0]            TUSER;
    logic [0:4][0:4][63:0] D_out;
    logic                  D_valid;
    logic                  D_ready;
    logic                  D_first;
    logic                  D_last;
    logic [1:0]            D_mode;

    int            checkCount = 0;
    int            passCount  = 0;
    logic [1599:0] expBlk;
    logic [63:0]   w00Snapshot;

    sha3_axis_absorber #(.DATA_WIDTH(64)) dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .TVALID  (TVALID),
        .TREADY  (TREADY),
        .TDATA   (TDATA),
        .TKEEP   (TKEEP),
        .TLAST   (TLAST),
        .TUSER   (TUSER),
        .D_out   (D_out),
        .D_valid (D_valid),
        .D_ready (D_ready),
        .D_first (D_first),
        .D_last  (D_last),
        .D_mode  (D_mode)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [63:0] pat(input int b);
        logic [7:0] v;
        v   = 8'(b);
        pat = {8{v}};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic checkBlock(input string tag);
        int          bad;
        logic [63:0] o;
        logic [63:0] e;
        bad = 0;
        o   = '0;
        e   = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                if (D_out[x][y] !== expBlk[64*(x+5*y) +: 64]) begin
                    if (bad == 0) begin
                        o = D_out[x][y];
                        e = expBlk[64*(x+5*y) +: 64];
                    end
                    bad++;
                end
            end
        end
        checkCount++;
        assert (bad === 0) passCount++;
        else $error("[TB] FAIL %s: %0d lanes differ, first lane observed %h expected %h", tag, bad, o, e);
    endtask

    task automatic applyStimulus(input logic [63:0] data, input logic [7:0] keep,
                                 input logic last, input logic [1:0] user);
        int guard;
        @(negedge ACLK);
        TVALID = 1'b1;
        TDATA  = data;
        TKEEP  = keep;
        TLAST  = last;
        TUSER  = user;
        guard  = 0;
        while (!TREADY && guard < 50) begin
            @(negedge ACLK);
            guard++;
        end
        if (guard >= 50) begin
            checkCount++;
            $error("[TB] FAIL beat_timeout: observed TREADY %b expected 1", TREADY);
        end
        @(posedge ACLK);
        #1;
        TVALID = 1'b0;
        TLAST  = 1'b0;
    endtask

    task automatic handoff();
        D_ready = 1'b1;
        @(posedge ACLK);
        #1;
        D_ready = 1'b0;
    endtask

    task automatic padExp(input int rb);
        expBlk               = '0;
        expBlk[7:0]          = 8'h06;
        expBlk[8*(rb-1) +: 8] = 8'h80;
    endtask

    initial begin
        int seen;
        ARESET  = 1'b1;
        TVALID  = 1'b0;
        TDATA   = '0;
        TKEEP   = '0;
        TLAST   = 1'b0;
        TUSER   = '0;
        D_ready = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        checkOutput("reset_tready", 64'(TREADY), 64'd0);
        checkOutput("reset_dvalid", 64'(D_valid), 64'd0);
        expBlk = '0;
        checkBlock("reset_dout");
        checkOutput("reset_flags", {60'd0, D_mode, D_first, D_last}, 64'd0);
        ARESET = 1'b0;
        #1;
        checkOutput("fill_tready", 64'(TREADY), 64'd1);

        // Empty SHA3-256 message
        applyStimulus(64'h0, 8'h00, 1'b1, 2'd1);
        @(negedge ACLK);
        checkOutput("empty_dvalid", 64'(D_valid), 64'd1);
        checkOutput("empty_tready", 64'(TREADY), 64'd0);
        checkOutput("empty_flags", {60'd0, D_mode, D_first, D_last}, {60'd0, 2'd1, 1'b1, 1'b1});
        padExp(136);
        checkBlock("empty_block");
        handoff();
        @(negedge ACLK);
        checkOutput("empty_after", 64'(D_valid), 64'd0);

        // "abc", SHA3-256
        applyStimulus(64'h0000000000636261, 8'h07, 1'b1, 2'd1);
        @(negedge ACLK);
        checkOutput("abc_lane00", D_out[0][0], 64'h0000000006636261);
        checkOutput("abc_flags", {60'd0, D_mode, D_first, D_last}, {60'd0, 2'd1, 1'b1, 1'b1});
        padExp(136);
        expBlk[63:0] = 64'h0000000006636261;
        checkBlock("abc_block");
        handoff();

        // 136-byte SHA3-256 message: full block then padding-only block
        for (int i = 0; i < 17; i++) applyStimulus(pat(i + 1), 8'hFF, i == 16, 2'd1);
        @(negedge ACLK);
        expBlk = '0;
        for (int i = 0; i < 17; i++) expBlk[64*i +: 64] = pat(i + 1);
        checkOutput("b136_dvalid", 64'(D_valid), 64'd1);
        checkOutput("b136_flags1", {60'd0, D_mode, D_first, D_last}, {60'd0, 2'd1, 1'b1, 1'b0});
        checkBlock("b136_block1");
        handoff();
        @(negedge ACLK);
        checkOutput("b136_padgap", 64'(D_valid), 64'd0);
        @(negedge ACLK);
        checkOutput("b136_padvalid", 64'(D_valid), 64'd1);
        checkOutput("b136_flags2", {60'd0, D_mode, D_first, D_last}, {60'd0, 2'd1, 1'b0, 1'b1});
        padExp(136);
        checkBlock("b136_block2");
        handoff();

        // 71-byte SHA3-512 message, byte 71 becomes 0x86
        for (int i = 0; i < 8; i++) applyStimulus(pat(i + 16), 8'hFF, 1'b0, 2'd3);
        applyStimulus(64'hFF47464544434241, 8'h7F, 1'b1, 2'd3);
        @(negedge ACLK);
        expBlk = '0;
        for (int i = 0; i < 8; i++) expBlk[64*i +: 64] = pat(i + 16);
        expBlk[64*8 +: 64] = 64'h8647464544434241;
        checkOutput("b71_flags", {60'd0, D_mode, D_first, D_last}, {60'd0, 2'd3, 1'b1, 1'b1});
        checkBlock("b71_block");
        handoff();

        // 200-byte SHA3-224 message with downstream backpressure
        for (int i = 0; i < 18; i++) applyStimulus(pat(i + 32), 8'hFF, 1'b0, (i == 0) ? 2'd0 : 2'd3);
        expBlk = '0;
        for (int i = 0; i < 18; i++) expBlk[64*i +: 64] = pat(i + 32);
        @(negedge ACLK);
        w00Snapshot = D_out[0][0];
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge ACLK);
            checkOutput("bp_dvalid", 64'(D_valid), 64'd1);
            checkOutput("bp_tready", 64'(TREADY), 64'd0);
            checkBlock("bp_block1");
        end
        checkOutput("bp_stable00", D_out[0][0], pat(32));
        checkOutput("bp_flags1", {60'd0, D_mode, D_first, D_last}, {60'd0, 2'd0, 1'b1, 1'b0});
        handoff();
        for (int i = 18; i < 25; i++) applyStimulus(pat(i + 32), 8'hFF, i == 24, 2'd3);
        @(negedge ACLK);
        expBlk = '0;
        for (int i = 18; i < 25; i++) expBlk[64*(i-18) +: 64] = pat(i + 32);
        expBlk[8*56 +: 8]  = 8'h06;
        expBlk[8*143 +: 8] = 8'h80;
        checkOutput("bp_flags2", {60'd0, D_mode, D_first, D_last}, {60'd0, 2'd0, 1'b0, 1'b1});
        checkBlock("bp_block2");
        handoff();

        // Reset mid-message, then empty SHA3-384 message
        for (int i = 0; i < 5; i++) applyStimulus(pat(i + 64), 8'hFF, 1'b0, 2'd0);
        ARESET = 1'b1;
        @(negedge ACLK);
        checkOutput("midrst_tready", 64'(TREADY), 64'd0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        applyStimulus(64'h0, 8'h00, 1'b1, 2'd2);
        @(negedge ACLK);
        checkOutput("rst384_flags", {60'd0, D_mode, D_first, D_last}, {60'd0, 2'd2, 1'b1, 1'b1});
        padExp(104);
        checkBlock("rst384_block");
        handoff();
        seen = 0;
        repeat (4) begin
            @(negedge ACLK);
            if (D_valid) seen++;
        end
        checkOutput("rst384_noextra", 64'(seen), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
